// File: rtl/mydesign_pipe_top.sv
// ============================================================================
// mydesign_pipe_top
// ----------------------------------------------------------------------------
// A multi-lane pipelined wrapper around mydesign_comb, used as a
// timing-closed top for flow runs. Each lane has its own mydesign_comb
// instance, marked dont_touch so that every lane appears in area reports.
//
// The beats move through S = IN_STAGES + OUT_STAGES register stages, and every
// stage has a valid bit. mydesign_comb sits between stage IN_STAGES-1 and
// stage IN_STAGES. When IN_STAGES is 0, it is driven straight from the
// operand ports. The valid/ready handshake supports backpressure. Bubbles
// collapse, and ready_o is the combinational load condition of stage 0.
//
// mydesign_comb computes the unsigned product a*b of the two N_IN-bit lane
// operands, presented on N_OUT bits. If N_OUT is narrower than the product,
// the high bits are dropped; if it is wider, the product is zero-extended.
//
// Parameters
//   N_IN        operand width per lane
//   N_OUT       result width per lane
//   N_LANES     number of parallel lanes (>=1)
//   IN_STAGES   register stages in front of the comb logic (0..4)
//   OUT_STAGES  register stages behind the comb logic (1..4)
//
// Ports
//   clk_ci       in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   valid_i      in   input beat valid
//   ready_o      out  wrapper can accept an input beat
//   operand_a_i  in   N_LANES*N_IN, lane l at [l*N_IN +: N_IN]
//   operand_b_i  in   N_LANES*N_IN, lane l at [l*N_IN +: N_IN]
//   valid_o      out  result beat valid
//   ready_i      in   downstream accepts the result beat
//   result_o     out  N_LANES*N_OUT, lane l at [l*N_OUT +: N_OUT]
//   beat_cnt_o   out  32-bit count of output handshakes; present only when
//                     MYDESIGN_PIPE_BEAT_CNT_EN is defined
//
// Build option
//   MYDESIGN_PIPE_BEAT_CNT_EN : adds the beat_cnt_o port and its counter.
//                               The default build has neither.
// ============================================================================

module mydesign_comb #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 6
) (
    input  logic [N_IN-1:0]  a,
    input  logic [N_IN-1:0]  b,
    output logic [N_OUT-1:0] y
);
    localparam int PW = 2 * N_IN;

    logic [PW-1:0] prod;

    assign prod = a * b;

    generate
        if (N_OUT > PW) begin : g_ext
            assign y = {{(N_OUT - PW){1'b0}}, prod};
        end else if (N_OUT == PW) begin : g_eq
            assign y = prod;
        end else begin : g_trunc
            assign y = prod[N_OUT-1:0];
        end
    endgenerate
endmodule

module mydesign_pipe_top #(
    parameter int N_IN       = 3,
    parameter int N_OUT      = 6,
    parameter int N_LANES    = 1,
    parameter int IN_STAGES  = 1,
    parameter int OUT_STAGES = 1
) (
    input  logic                       clk_ci,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [N_LANES*N_IN-1:0]    operand_a_i,
    input  logic [N_LANES*N_IN-1:0]    operand_b_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [N_LANES*N_OUT-1:0]   result_o
`ifdef MYDESIGN_PIPE_BEAT_CNT_EN
    ,
    output logic [31:0]                beat_cnt_o
`endif
);
    localparam int S        = IN_STAGES + OUT_STAGES;
    localparam int A_W      = N_LANES * N_IN;
    localparam int OP_W     = 2 * A_W;
    localparam int RES_W    = N_LANES * N_OUT;
    // The input-side array always has at least one entry, so that it stays
    // legal when IN_STAGES is 0. That entry is never used in that case.
    localparam int IN_DEPTH = (IN_STAGES > 0) ? IN_STAGES : 1;

    logic [S-1:0]      valid_reg;
    logic [S-1:0]      load;
    logic [S-1:0]      up_valid;

    // Operand pairs are packed as {b, a}, so that lane slices are the same
    // in every input stage.
    logic [OP_W-1:0]   in_data_reg [IN_DEPTH];
    logic [OP_W-1:0]   in_chain    [IN_STAGES+1];
    logic [RES_W-1:0]  out_data_reg[OUT_STAGES];
    logic [RES_W-1:0]  out_chain   [OUT_STAGES];
    logic [RES_W-1:0]  comb_result;

    // ------------------------------------------------------------------
    // Upstream valid for each stage: valid_i feeds stage 0, and every
    // other stage is fed by the valid bit of its predecessor.
    // ------------------------------------------------------------------
    generate
        if (S == 1) begin : g_upv_single
            assign up_valid = valid_i;
        end else begin : g_upv_chain
            assign up_valid = {valid_reg[S-2:0], valid_i};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Data chains: element k is the data offered to the stage at
    // position k within its section.
    // ------------------------------------------------------------------
    assign in_chain[0] = {operand_b_i, operand_a_i};

    generate
        for (genvar gi = 0; gi < IN_STAGES; gi++) begin : g_in_chain
            assign in_chain[gi+1] = in_data_reg[gi];
        end
    endgenerate

    assign out_chain[0] = comb_result;

    generate
        for (genvar gi = 1; gi < OUT_STAGES; gi++) begin : g_out_chain
            assign out_chain[gi] = out_data_reg[gi-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // One comb instance per lane. Lane data never crosses lanes.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [N_IN-1:0] lane_a;
            logic [N_IN-1:0] lane_b;

            assign lane_a = in_chain[IN_STAGES][gi*N_IN +: N_IN];
            assign lane_b = in_chain[IN_STAGES][A_W + gi*N_IN +: N_IN];

            (* dont_touch = "true" *)
            mydesign_comb #(
                .N_IN  (N_IN),
                .N_OUT (N_OUT)
            ) u_comb (
                .a (lane_a),
                .b (lane_b),
                .y (comb_result[gi*N_OUT +: N_OUT])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load conditions run backwards from the sink. A stage may take new
    // data when it is empty or when its content moves on in this cycle.
    // This lets bubbles collapse, and the pipe runs at one beat per
    // cycle when ready_i is held high.
    // ------------------------------------------------------------------
    always_comb begin
        load      = '0;
        load[S-1] = ~valid_reg[S-1] | ready_i;
        for (int k = S - 2; k >= 0; k--) begin
            load[k] = ~valid_reg[k] | load[k+1];
        end
    end

    assign ready_o  = load[0];
    assign valid_o  = valid_reg[S-1];
    assign result_o = out_data_reg[OUT_STAGES-1];

    // ------------------------------------------------------------------
    // Stage registers. A stage that loads a bubble clears only its valid
    // bit and keeps its data, so the data regs do not toggle on idle
    // cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= '0;
            for (int k = 0; k < IN_DEPTH; k++) begin
                in_data_reg[k] <= '0;
            end
            for (int j = 0; j < OUT_STAGES; j++) begin
                out_data_reg[j] <= '0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                if (load[k]) begin
                    valid_reg[k] <= up_valid[k];
                end
            end
            for (int k = 0; k < IN_STAGES; k++) begin
                if (load[k] && up_valid[k]) begin
                    in_data_reg[k] <= in_chain[k];
                end
            end
            for (int j = 0; j < OUT_STAGES; j++) begin
                if (load[IN_STAGES+j] && up_valid[IN_STAGES+j]) begin
                    out_data_reg[j] <= out_chain[j];
                end
            end
        end
    end

`ifdef MYDESIGN_PIPE_BEAT_CNT_EN
    // ------------------------------------------------------------------
    // Output handshake counter. It wraps naturally at 2^32. It is written
    // only on a handshake, so a value placed in it holds until the next
    // beat leaves.
    // ------------------------------------------------------------------
    logic [31:0] beat_cnt_reg;

    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_reg <= '0;
        end else if (valid_o && ready_i) begin
            beat_cnt_reg <= beat_cnt_reg + 32'd1;
        end
    end

    assign beat_cnt_o = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_mydesign_pipe_top.sv
// ============================================================================
// tb_mydesign_pipe_top
// ----------------------------------------------------------------------------
// Scoreboard bench for mydesign_pipe_top.
// - The main DUT uses 2 lanes with IN=1 and OUT=1. Every accepted beat
//   pushes its expected lane products onto a queue. A negedge monitor
//   compares result_o against the head of that queue whenever valid_o is
//   high, and pops the head on each output handshake. The monitor also
//   checks ready_o against a model based on occupancy: the pipe refuses
//   input only when it holds S beats and ready_i is low.
// - The second DUT uses 1 lane with IN=0 and OUT=4. It is driven with an
//   alternating valid pattern, and the bench checks that valid_o is the
//   same pattern delayed by 4 cycles.
// ============================================================================
`timescale 1ns/1ps

module tb_mydesign_pipe_top;
    localparam int NL = 2;
    localparam int NI = 3;
    localparam int NO = 6;
    localparam int S  = 2;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                valid_i;
    logic                ready_o;
    logic [NL*NI-1:0]    operand_a;
    logic [NL*NI-1:0]    operand_b;
    logic                valid_o;
    logic                ready_i;
    logic [NL*NO-1:0]    result;
`ifdef MYDESIGN_PIPE_BEAT_CNT_EN
    logic [31:0]         beat_cnt;
    logic [31:0]         beat_cnt4;
`endif

    logic                valid4;
    logic                ready_o4;
    logic [NI-1:0]       a4;
    logic [NI-1:0]       b4;
    logic                valid_o4;
    logic                ready4;
    logic [NO-1:0]       result4;

    always #5 clk = ~clk;

    mydesign_pipe_top #(
        .N_IN(NI), .N_OUT(NO), .N_LANES(NL), .IN_STAGES(1), .OUT_STAGES(1)
    ) dut (
        .clk_ci      (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result)
`ifdef MYDESIGN_PIPE_BEAT_CNT_EN
        ,
        .beat_cnt_o  (beat_cnt)
`endif
    );

    mydesign_pipe_top #(
        .N_IN(NI), .N_OUT(NO), .N_LANES(1), .IN_STAGES(0), .OUT_STAGES(4)
    ) dut4 (
        .clk_ci      (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid4),
        .ready_o     (ready_o4),
        .operand_a_i (a4),
        .operand_b_i (b4),
        .valid_o     (valid_o4),
        .ready_i     (ready4),
        .result_o    (result4)
`ifdef MYDESIGN_PIPE_BEAT_CNT_EN
        ,
        .beat_cnt_o  (beat_cnt4)
`endif
    );

    typedef struct {
        logic [NL*NO-1:0] res;
        int               acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   n_emit   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    bit   lat_mode = 1'b1;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: each lane result is the plain product of its two operands,
    // reduced to NO bits.
    function automatic logic [NL*NO-1:0] model(input logic [NL*NI-1:0] a, input logic [NL*NI-1:0] b);
        logic [NL*NO-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) begin
            int x;
            int y;
            int p;
            x = int'(a[l*NI +: NI]);
            y = int'(b[l*NI +: NI]);
            p = (x * y) % (1 << NO);
            r[l*NO +: NO] = p[NO-1:0];
        end
        return r;
    endfunction

    // Monitor / scoreboard. It samples on the negedge, away from the active
    // edge. It handles the output before the input, so that a beat accepted
    // in this cycle cannot be mistaken for one leaving in this cycle.
    always @(negedge clk) begin
        if (rst_ni && mon_en) begin
            check("ready_o", 32'(ready_o), 32'((exp_q.size() < S) || ready_i));
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp  = n_cmp + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL spurious_valid: got valid_o=1 result=0x%0h, expected no beat (cycle %0d)", result, cyc);
                end else begin
                    check("result", 32'(result), 32'(exp_q[0].res));
                    if (ready_i) begin
                        if (lat_mode) check("latency", 32'(cyc + 1 - exp_q[0].acc), 32'(S));
                        void'(exp_q.pop_front());
                        n_emit = n_emit + 1;
                    end
                end
            end
            if (valid_i && ready_o) begin
                exp_t e;
                e.res = model(operand_a, operand_b);
                e.acc = cyc + 1;
                exp_q.push_back(e);
            end
        end
    end

    // Presents one beat and holds it until it is accepted. Called at
    // posedge+1, and returns at posedge+1 after the accepting edge.
    task automatic send(input logic [NL*NI-1:0] av, input logic [NL*NI-1:0] bv);
        int w;
        valid_i   = 1'b1;
        operand_a = av;
        operand_b = bv;
        w = 0;
        @(negedge clk);
        while (!ready_o && w < 100) begin
            w = w + 1;
            @(negedge clk);
        end
        if (w >= 100) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL send_timeout: got ready_o=0 for 100 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        ready_i = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk);
            w = w + 1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        bit vh[$];
        logic [NO-1:0] rh[$];

        rst_ni    = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        operand_a = '0;
        operand_b = '0;
        valid4    = 1'b0;
        ready4    = 1'b1;
        a4        = '0;
        b4        = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_result_o", 32'(result), 32'd0);
        rst_ni = 1'b1;
        #1;
        check("reset_ready_o", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Test 1: directed two-lane beat (lane0 3*5=15, lane1 7*1=7); latency 2
        e0 = n_emit;
        send({3'd7, 3'd3}, {3'd1, 3'd5});
        drain();
        check("directed_count", 32'(n_emit - e0), 32'd1);

        // Test 2: 16 random back-to-back beats with ready_i=1
        e0 = n_emit;
        for (int i = 0; i < 16; i++) send(6'($urandom), 6'($urandom));
        drain();
        check("stream_count", 32'(n_emit - e0), 32'd16);

`ifdef MYDESIGN_PIPE_BEAT_CNT_EN
        check("beat_cnt_total", beat_cnt, 32'(n_emit));
        force dut.beat_cnt_reg = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.beat_cnt_reg;
        for (int i = 0; i < 3; i++) send(6'($urandom), 6'($urandom));
        drain();
        check("beat_cnt_wrap", beat_cnt, 32'd1);
`endif

        // Test 3: backpressure for 6 cycles while streaming 8 beats
        lat_mode = 1'b0;
        e0 = n_emit;
        fork
            begin
                for (int i = 0; i < 8; i++) send(6'($urandom), 6'($urandom));
            end
            begin
                ready_i = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();
        check("stall_count", 32'(n_emit - e0), 32'd8);

        // Test 4: reset with two beats in flight (pipe full, stalled)
        ready_i = 1'b0;
        send(6'($urandom), 6'($urandom));
        send(6'($urandom), 6'($urandom));
        check("inflight_count", 32'(exp_q.size()), 32'd2);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check("midrst_result_o", 32'(result), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_valid_o", 32'(valid_o), 32'd0);
        check("postrst_ready_o", 32'(ready_o), 32'd1);

        // Test 5: IN=0, OUT=4 with alternating valid; valid_o is the input pattern delayed by 4
        for (int t = 0; t < 28; t++) begin
            int x;
            int y;
            @(posedge clk);
            #1;
            valid4 = (t < 16) && (t % 2 == 0);
            a4 = 3'($urandom);
            b4 = 3'($urandom);
            x = int'(a4);
            y = int'(b4);
            vh.push_back(valid4);
            rh.push_back(6'(x * y));
            @(negedge clk);
            check("ready_o4", 32'(ready_o4), 32'd1);
            if (t >= 4) begin
                check("valid_o4", 32'(valid_o4), 32'(vh[t-4]));
                if (vh[t-4]) check("result4", 32'(result4), 32'(rh[t-4]));
            end else begin
                check("valid_o4", 32'(valid_o4), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        valid4 = 1'b0;

        // Random traffic with random backpressure and gaps
        e0 = n_emit;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(6'($urandom), 6'($urandom));
                    if ($urandom_range(0, 2) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                repeat (250) begin
                    @(posedge clk);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join
        drain();
        check("random_count", 32'(n_emit - e0), 32'd60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
